// File: rtl/mux_pkg.sv
// Shared types and sizing helpers for the N-to-1 stream multiplexer.
//   mode_e    : arbitration mode (explicit select or round-robin)
//   sel_width : width of a channel index for a given channel count
package mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

    // Channel index width; never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_nto1_rr_arbiter.sv
// Round-robin priority search: grants the first requester at or above ptr,
// wrapping modulo N_IN.
//   req : per-channel request
//   ptr : highest-priority channel index (always < N_IN)
//   gnt : one-hot grant, zero when no request
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned PTR_W = sel_width(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_IN-1:0]  gnt
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Walk channels ptr, ptr+1, ... and keep the first requester.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            idx = PTR_W'((32'(ptr) + k) % N_IN);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_nto1.sv
// N-to-1 valid/ready stream multiplexer with a single output register stage.
// Arbitration is either an explicit channel select or round-robin.
//   clk, rst_n : clock, synchronous active-low reset
//   mode       : 0 = explicit select, 1 = round-robin
//   sel        : channel index used in select mode
//   in_data    : packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   : per-channel valid
//   in_ready   : per-channel ready (combinational, one-hot or zero)
//   y, y_valid : registered output word and its valid
//   y_ready    : downstream accept
//   y_src      : index of the channel that supplied y
module stream_mux_nto1
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_IN  = 4,
    localparam int unsigned SEL_W = sel_width(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]      y,
    output logic                  y_valid,
    input  logic                  y_ready,
    output logic [SEL_W-1:0]      y_src
);

    mode_e            mode_s;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic [SEL_W-1:0] y_src_q, y_src_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_IN-1:0]  sel_gnt, rr_gnt, grant;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             take, xfer;

    assign mode_s = mode_e'(mode);

    rr_arbiter #(
        .N_IN  (N_IN),
        .PTR_W (SEL_W)
    ) u_rr_arbiter (
        .req (in_valid),
        .ptr (rr_ptr_q),
        .gnt (rr_gnt)
    );

    // Grant decision; an out-of-range select grants nothing.
    always_comb begin
        sel_gnt = '0;
        if (32'(sel) < N_IN) begin
            sel_gnt[sel] = in_valid[sel];
        end
        grant = (mode_s == MODE_RR) ? rr_gnt : sel_gnt;
    end

    // Output register can load when empty or draining this cycle.
    assign take     = !y_valid_q || y_ready;
    assign in_ready = rst_n ? (grant & {N_IN{take}}) : '0;
    assign xfer     = |in_ready;

    // One-hot grant to index and data.
    always_comb begin
        gnt_idx  = '0;
        gnt_data = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (grant[i]) begin
                gnt_idx  = SEL_W'(i);
                gnt_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state: load on transfer, empty on idle take, hold on stall.
    always_comb begin
        y_d       = y_q;
        y_valid_d = y_valid_q;
        y_src_d   = y_src_q;
        rr_ptr_d  = rr_ptr_q;
        if (take) begin
            y_valid_d = xfer;
            if (xfer) begin
                y_d     = gnt_data;
                y_src_d = gnt_idx;
            end
        end
        if (xfer && (mode_s == MODE_RR)) begin
            rr_ptr_d = (32'(gnt_idx) == (N_IN - 1)) ? '0 : (gnt_idx + SEL_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_src_q   <= '0;
            rr_ptr_q  <= '0;
        end else begin
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            y_src_q   <= y_src_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign y_src   = y_src_q;

endmodule

// File: tb/tb_stream_mux_nto1.sv
// Directed bench for stream_mux_nto1: a 4-channel instance driven from a
// vector table plus reset sequences, and a 3-channel instance for the
// out-of-range select and non-power-of-two round-robin wrap.
module tb_stream_mux_nto1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4-channel instance
    logic        rst4_n, mode4, yv4, yr4;
    logic [1:0]  sel4, src4;
    logic [31:0] data4;
    logic [3:0]  iv4, ir4;
    logic [7:0]  y4;

    // 3-channel instance
    logic        rst3_n, mode3, yv3, yr3;
    logic [1:0]  sel3, src3;
    logic [23:0] data3;
    logic [2:0]  iv3, ir3;
    logic [7:0]  y3;

    stream_mux_nto1 #(.WIDTH(8), .N_IN(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .mode(mode4), .sel(sel4),
        .in_data(data4), .in_valid(iv4), .in_ready(ir4),
        .y(y4), .y_valid(yv4), .y_ready(yr4), .y_src(src4)
    );

    stream_mux_nto1 #(.WIDTH(8), .N_IN(3)) u_dut3 (
        .clk(clk), .rst_n(rst3_n), .mode(mode3), .sel(sel3),
        .in_data(data3), .in_valid(iv3), .in_ready(ir3),
        .y(y3), .y_valid(yv3), .y_ready(yr3), .y_src(src3)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        mode;
        logic [1:0]  sel;
        logic [3:0]  iv;
        logic        yr;
        logic [31:0] data;
        logic [3:0]  exp_ir;
        logic        exp_yv;
        logic [7:0]  exp_y;
        logic [1:0]  exp_src;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl[NV];

    localparam logic [31:0] D  = 32'h4433_2211;
    localparam logic [31:0] DA = 32'h44A5_2211;

    function automatic vec_t mk(input logic m, input logic [1:0] s, input logic [3:0] iv,
                                input logic yr, input logic [31:0] d, input logic [3:0] eir,
                                input logic eyv, input logic [7:0] ey, input logic [1:0] esrc);
        vec_t v;
        v.mode = m; v.sel = s; v.iv = iv; v.yr = yr; v.data = d;
        v.exp_ir = eir; v.exp_yv = eyv; v.exp_y = ey; v.exp_src = esrc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // mode, sel, iv, yr, data, exp in_ready, exp y_valid, exp y, exp y_src
        tbl[0]  = mk(1'b0, 2'd2, 4'b0100, 1'b1, DA, 4'b0100, 1'b1, 8'hA5, 2'd2);
        tbl[1]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, D,  4'b0001, 1'b1, 8'h11, 2'd0);
        tbl[2]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, D,  4'b0010, 1'b1, 8'h22, 2'd1);
        tbl[3]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, D,  4'b0100, 1'b1, 8'h33, 2'd2);
        tbl[4]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, D,  4'b1000, 1'b1, 8'h44, 2'd3);
        tbl[5]  = mk(1'b1, 2'd0, 4'b1111, 1'b1, D,  4'b0001, 1'b1, 8'h11, 2'd0);
        tbl[6]  = mk(1'b1, 2'd0, 4'b0100, 1'b1, D,  4'b0100, 1'b1, 8'h33, 2'd2);
        tbl[7]  = mk(1'b1, 2'd0, 4'b0011, 1'b1, D,  4'b0001, 1'b1, 8'h11, 2'd0);
        tbl[8]  = mk(1'b1, 2'd0, 4'b0011, 1'b1, D,  4'b0010, 1'b1, 8'h22, 2'd1);
        tbl[9]  = mk(1'b0, 2'd3, 4'b1000, 1'b1, D,  4'b1000, 1'b1, 8'h44, 2'd3);
        tbl[10] = mk(1'b1, 2'd0, 4'b1111, 1'b1, D,  4'b0100, 1'b1, 8'h33, 2'd2);
        tbl[11] = mk(1'b1, 2'd0, 4'b0000, 1'b1, D,  4'b0000, 1'b0, 8'h00, 2'd0);
        tbl[12] = mk(1'b1, 2'd0, 4'b1111, 1'b1, D,  4'b1000, 1'b1, 8'h44, 2'd3);
        tbl[13] = mk(1'b0, 2'd1, 4'b1111, 1'b0, D,  4'b0000, 1'b1, 8'h44, 2'd3);
        tbl[14] = mk(1'b1, 2'd0, 4'b1111, 1'b0, D,  4'b0000, 1'b1, 8'h44, 2'd3);
        tbl[15] = mk(1'b1, 2'd2, 4'b1111, 1'b0, D,  4'b0000, 1'b1, 8'h44, 2'd3);
        tbl[16] = mk(1'b1, 2'd0, 4'b1111, 1'b1, D,  4'b0001, 1'b1, 8'h11, 2'd0);
        tbl[17] = mk(1'b1, 2'd0, 4'b0000, 1'b0, D,  4'b0000, 1'b1, 8'h11, 2'd0);
        tbl[18] = mk(1'b1, 2'd0, 4'b0000, 1'b1, D,  4'b0000, 1'b0, 8'h00, 2'd0);
        tbl[19] = mk(1'b0, 2'd0, 4'b0001, 1'b0, D,  4'b0001, 1'b1, 8'h11, 2'd0);

        rst4_n = 1'b0; mode4 = 1'b1; sel4 = 2'd0; data4 = D; iv4 = 4'b1111; yr4 = 1'b1;
        rst3_n = 1'b0; mode3 = 1'b0; sel3 = 2'd0; data3 = 24'h33_2211; iv3 = 3'b111; yr3 = 1'b1;

        // Reset state and in_ready suppression during reset
        step();
        step();
        chk("rst4_in_ready", 32'(ir4), 32'h0);
        chk("rst4_y_valid", 32'(yv4), 32'h0);
        chk("rst4_y", 32'(y4), 32'h0);
        chk("rst4_y_src", 32'(src4), 32'h0);
        chk("rst3_in_ready", 32'(ir3), 32'h0);
        rst4_n = 1'b1;
        rst3_n = 1'b1;
        iv4 = 4'b0000;
        iv3 = 3'b000;
        step();

        // Table-driven main sequence on the 4-channel instance
        for (int i = 0; i < NV; i++) begin
            mode4 = tbl[i].mode; sel4 = tbl[i].sel; iv4 = tbl[i].iv;
            yr4 = tbl[i].yr; data4 = tbl[i].data;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(ir4), 32'(tbl[i].exp_ir));
            step();
            chk($sformatf("v%0d_y_valid", i), 32'(yv4), 32'(tbl[i].exp_yv));
            if (tbl[i].exp_yv) begin
                chk($sformatf("v%0d_y", i), 32'(y4), 32'(tbl[i].exp_y));
                chk($sformatf("v%0d_y_src", i), 32'(src4), 32'(tbl[i].exp_src));
            end
        end

        // Reset with a word in flight (y=11, src 0, rr_ptr=1)
        mode4 = 1'b1; iv4 = 4'b1111; yr4 = 1'b1; rst4_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(ir4), 32'h0);
        step();
        chk("midrst_y_valid", 32'(yv4), 32'h0);
        chk("midrst_y", 32'(y4), 32'h0);
        chk("midrst_y_src", 32'(src4), 32'h0);
        rst4_n = 1'b1;
        #1;
        // rr_ptr back to 0: channel 0 wins, not channel 1
        chk("postrst_in_ready", 32'(ir4), 32'b0001);
        step();
        chk("postrst_y_src", 32'(src4), 32'h0);
        chk("postrst_y", 32'(y4), 32'h11);
        iv4 = 4'b0000;

        // 3-channel: load channel 0, then out-of-range select
        mode3 = 1'b0; sel3 = 2'd0; iv3 = 3'b111; yr3 = 1'b1;
        #1;
        chk("n3_sel0_in_ready", 32'(ir3), 32'b001);
        step();
        chk("n3_sel0_y", 32'(y3), 32'h11);
        chk("n3_sel0_y_valid", 32'(yv3), 32'h1);
        sel3 = 2'd3; yr3 = 1'b0;
        #1;
        chk("n3_sel3_hold_in_ready", 32'(ir3), 32'h0);
        step();
        chk("n3_sel3_hold_y_valid", 32'(yv3), 32'h1);
        yr3 = 1'b1;
        #1;
        chk("n3_sel3_drain_in_ready", 32'(ir3), 32'h0);
        step();
        chk("n3_sel3_drain_y_valid", 32'(yv3), 32'h0);
        #1;
        chk("n3_sel3_empty_in_ready", 32'(ir3), 32'h0);
        step();
        chk("n3_sel3_empty_y_valid", 32'(yv3), 32'h0);

        // 3-channel round-robin wraps 2 -> 0
        mode3 = 1'b1; iv3 = 3'b111;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("n3_rr%0d_in_ready", k), 32'(ir3), 32'(3'b001 << (k % 3)));
            step();
            chk($sformatf("n3_rr%0d_y_src", k), 32'(src3), 32'(k % 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
